// File: rtl/execute_stage_md_if.sv
// Decode-side inputs and execute-side outputs of the MIPS execute stage,
// grouped so the stage and its neighbours share one bundle.
interface execute_stage_md_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] EX_RD1D;
    logic [WIDTH-1:0] EX_RD2D;
    logic [4:0]       EX_RsD;
    logic [4:0]       EX_RtD;
    logic [4:0]       EX_RdD;
    logic [WIDTH-1:0] EX_SignImmD;
    logic             EX_RegWriteD;
    logic             EX_MemWriteD;
    logic             EX_MemToRegD;
    logic             EX_AluSrcD;
    logic             EX_RegDstD;
    logic [3:0]       EX_AluControlD;
    logic [2:0]       EX_MdOpD;
    logic             EX_FlushE;
    logic [WIDTH-1:0] EX_ResultW;
    logic [WIDTH-1:0] EX_AluOutM;
    logic [1:0]       EX_ForwardAE;
    logic [1:0]       EX_ForwardBE;

    logic [WIDTH-1:0] EX_AluOutE;
    logic [WIDTH-1:0] EX_WriteDataE;
    logic [4:0]       EX_WriteRegE;
    logic [4:0]       EX_RsE;
    logic [4:0]       EX_RtE;
    logic             EX_RegWriteE;
    logic             EX_MemWriteE;
    logic             EX_MemToRegE;
    logic             EX_ZeroE;
    logic             EX_MdBusyE;

    modport master (
        output EX_RD1D, EX_RD2D, EX_RsD, EX_RtD, EX_RdD, EX_SignImmD,
               EX_RegWriteD, EX_MemWriteD, EX_MemToRegD, EX_AluSrcD, EX_RegDstD,
               EX_AluControlD, EX_MdOpD, EX_FlushE, EX_ResultW, EX_AluOutM,
               EX_ForwardAE, EX_ForwardBE,
        input  EX_AluOutE, EX_WriteDataE, EX_WriteRegE, EX_RsE, EX_RtE,
               EX_RegWriteE, EX_MemWriteE, EX_MemToRegE, EX_ZeroE, EX_MdBusyE
    );

    modport slave (
        input  EX_RD1D, EX_RD2D, EX_RsD, EX_RtD, EX_RdD, EX_SignImmD,
               EX_RegWriteD, EX_MemWriteD, EX_MemToRegD, EX_AluSrcD, EX_RegDstD,
               EX_AluControlD, EX_MdOpD, EX_FlushE, EX_ResultW, EX_AluOutM,
               EX_ForwardAE, EX_ForwardBE,
        output EX_AluOutE, EX_WriteDataE, EX_WriteRegE, EX_RsE, EX_RtE,
               EX_RegWriteE, EX_MemWriteE, EX_MemToRegE, EX_ZeroE, EX_MdBusyE
    );
endinterface

// File: rtl/execute_stage_md.sv
// MIPS execute stage: D->E register, forwarding, 4-bit ALU and an iterative
// multiply/divide unit that owns HI/LO and stalls the pipe while it works.
module execute_stage_md #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 4
) (
    input  logic              EX_CLK,
    input  logic              EX_RST,
    execute_stage_md_if.slave ex
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = (SW + 1 > 5) ? SW + 1 : 5;
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 2);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {MD_IDLE, MD_MUL, MD_DIV, MD_DONE} md_state_t;

    logic [WIDTH-1:0] rd1_reg, rd2_reg, imm_reg;
    logic [4:0]       rs_reg, rt_reg, rd_reg;
    logic             reg_write_reg, mem_write_reg, mem_to_reg_reg, alu_src_reg, reg_dst_reg;
    logic [3:0]       alu_ctl_reg;
    logic [2:0]       md_op_reg;
    logic             md_busy;

    // A busy multiply/divide pins its instruction in E; flush cannot evict it.
    always_ff @(posedge EX_CLK) begin
        if (EX_RST || (!md_busy && ex.EX_FlushE)) begin
            rd1_reg        <= '0;
            rd2_reg        <= '0;
            imm_reg        <= '0;
            rs_reg         <= '0;
            rt_reg         <= '0;
            rd_reg         <= '0;
            reg_write_reg  <= 1'b0;
            mem_write_reg  <= 1'b0;
            mem_to_reg_reg <= 1'b0;
            alu_src_reg    <= 1'b0;
            reg_dst_reg    <= 1'b0;
            alu_ctl_reg    <= '0;
            md_op_reg      <= '0;
        end else if (!md_busy) begin
            rd1_reg        <= ex.EX_RD1D;
            rd2_reg        <= ex.EX_RD2D;
            imm_reg        <= ex.EX_SignImmD;
            rs_reg         <= ex.EX_RsD;
            rt_reg         <= ex.EX_RtD;
            rd_reg         <= ex.EX_RdD;
            reg_write_reg  <= ex.EX_RegWriteD;
            mem_write_reg  <= ex.EX_MemWriteD;
            mem_to_reg_reg <= ex.EX_MemToRegD;
            alu_src_reg    <= ex.EX_AluSrcD;
            reg_dst_reg    <= ex.EX_RegDstD;
            alu_ctl_reg    <= ex.EX_AluControlD;
            md_op_reg      <= ex.EX_MdOpD;
        end
    end

    function automatic logic [WIDTH-1:0] fwd_mux(input logic [1:0] sel, input logic [WIDTH-1:0] r,
                                                 input logic [WIDTH-1:0] w, input logic [WIDTH-1:0] m);
        case (sel)
            2'b00:   return r;
            2'b01:   return w;
            2'b10:   return m;
            default: return '0;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
        return (s && x[WIDTH-1]) ? -x : x;
    endfunction

    logic [WIDTH-1:0] src_a, fwd_b, src_b, alu_res, alu_out;
    logic [SW-1:0]    shamt;

    assign src_a = fwd_mux(ex.EX_ForwardAE, rd1_reg, ex.EX_ResultW, ex.EX_AluOutM);
    assign fwd_b = fwd_mux(ex.EX_ForwardBE, rd2_reg, ex.EX_ResultW, ex.EX_AluOutM);
    assign src_b = alu_src_reg ? imm_reg : fwd_b;
    assign shamt = src_a[SW-1:0];

    always_comb begin
        alu_res = '0;
        case (alu_ctl_reg)
            4'b0000: alu_res = src_a & src_b;
            4'b0001: alu_res = src_a | src_b;
            4'b0010: alu_res = src_a + src_b;
            4'b0011: alu_res = src_a ^ src_b;
            4'b0100: alu_res = ~(src_a | src_b);
            4'b0101: alu_res = {{(WIDTH-1){1'b0}}, src_a < src_b};
            4'b0110: alu_res = src_a - src_b;
            4'b0111: alu_res = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            4'b1000: alu_res = src_b << shamt;
            4'b1001: alu_res = src_b >> shamt;
            4'b1010: alu_res = $unsigned($signed(src_b) >>> shamt);
            4'b1011: alu_res = src_b << (WIDTH / 2);
            default: alu_res = '0;
        endcase
    end

    md_state_t        state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] a_reg, a_next, b_reg, b_next, dvs_reg, dvs_next;
    logic [WIDTH-1:0] quo_reg, quo_next, rem_reg, rem_next, hi_reg, hi_next, lo_reg, lo_next;
    logic             sgn_reg, sgn_next;
    logic             md_start, start_signed, start_mul;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH-1:0] quo_step, rem_step, lo_fin, hi_fin;

    assign md_start     = (md_op_reg >= 3'b001) && (md_op_reg <= 3'b100);
    assign start_signed = (md_op_reg == 3'b001) || (md_op_reg == 3'b011);
    assign start_mul    = (md_op_reg == 3'b001) || (md_op_reg == 3'b010);

    // Sign-extending to 2*WIDTH makes one unsigned multiplier serve both signednesses.
    assign product = {{WIDTH{sgn_reg & a_reg[WIDTH-1]}}, a_reg} *
                     {{WIDTH{sgn_reg & b_reg[WIDTH-1]}}, b_reg};

    // quo_reg shifts dividend bits out of the top while quotient bits enter the bottom.
    assign div_trial = {rem_reg, quo_reg[WIDTH-1]} - {1'b0, dvs_reg};
    assign rem_step  = div_trial[WIDTH] ? {rem_reg[WIDTH-2:0], quo_reg[WIDTH-1]} : div_trial[WIDTH-1:0];
    assign quo_step  = {quo_reg[WIDTH-2:0], ~div_trial[WIDTH]};
    assign lo_fin    = (b_reg == '0) ? '1 :
                       ((sgn_reg && (a_reg[WIDTH-1] ^ b_reg[WIDTH-1])) ? -quo_step : quo_step);
    assign hi_fin    = (b_reg == '0) ? a_reg : ((sgn_reg && a_reg[WIDTH-1]) ? -rem_step : rem_step);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        sgn_next   = sgn_reg;
        dvs_next   = dvs_reg;
        quo_next   = quo_reg;
        rem_next   = rem_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        md_busy    = 1'b0;
        case (state_reg)
            MD_IDLE: begin
                if (md_start) begin
                    md_busy    = 1'b1;
                    a_next     = src_a;
                    b_next     = src_b;
                    sgn_next   = start_signed;
                    dvs_next   = mag(src_b, start_signed);
                    quo_next   = mag(src_a, start_signed);
                    rem_next   = '0;
                    cnt_next   = '0;
                    state_next = start_mul ? MD_MUL : MD_DIV;
                end
            end
            MD_MUL: begin
                md_busy  = 1'b1;
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == MUL_LAST) begin
                    {hi_next, lo_next} = product;
                    state_next         = MD_DONE;
                end
            end
            MD_DIV: begin
                md_busy  = 1'b1;
                cnt_next = cnt_reg + 1'b1;
                quo_next = quo_step;
                rem_next = rem_step;
                if (cnt_reg == DIV_LAST) begin
                    lo_next    = lo_fin;
                    hi_next    = hi_fin;
                    state_next = MD_DONE;
                end
            end
            default: state_next = MD_IDLE;
        endcase
    end

    always_ff @(posedge EX_CLK) begin
        if (EX_RST) begin
            state_reg <= MD_IDLE;
            cnt_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            sgn_reg   <= 1'b0;
            dvs_reg   <= '0;
            quo_reg   <= '0;
            rem_reg   <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            sgn_reg   <= sgn_next;
            dvs_reg   <= dvs_next;
            quo_reg   <= quo_next;
            rem_reg   <= rem_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
        end
    end

    assign alu_out = (md_op_reg == 3'b101) ? hi_reg :
                     (md_op_reg == 3'b110) ? lo_reg : alu_res;

    assign ex.EX_AluOutE    = alu_out;
    assign ex.EX_WriteDataE = fwd_b;
    assign ex.EX_WriteRegE  = reg_dst_reg ? rd_reg : rt_reg;
    assign ex.EX_RsE        = rs_reg;
    assign ex.EX_RtE        = rt_reg;
    assign ex.EX_RegWriteE  = reg_write_reg;
    assign ex.EX_MemWriteE  = mem_write_reg;
    assign ex.EX_MemToRegE  = mem_to_reg_reg;
    assign ex.EX_ZeroE      = (alu_out == '0);
    assign ex.EX_MdBusyE    = md_busy;
endmodule
